// File: rtl/lc3_ctrl_pkg.sv
// Shared types and encodings for the LC-3 control unit.
package lc3_ctrl_pkg;

    typedef enum logic [4:0] {
        StHalted,
        StFetch1,
        StFetch2,
        StFetch3,
        StDecode,
        StAdd,
        StAnd,
        StNot,
        StBr,
        StBrTaken,
        StJmp,
        StJsr1,
        StJsr2,
        StLdr1,
        StLdr2,
        StLdr3,
        StStr1,
        StStr2,
        StStr3,
        StPause1,
        StPause2
    } state_t;

    // Opcodes (IR[15:12]) that the sequencer decodes
    localparam logic [3:0] OpBr    = 4'b0000;
    localparam logic [3:0] OpAdd   = 4'b0001;
    localparam logic [3:0] OpJsr   = 4'b0100;
    localparam logic [3:0] OpAnd   = 4'b0101;
    localparam logic [3:0] OpLdr   = 4'b0110;
    localparam logic [3:0] OpStr   = 4'b0111;
    localparam logic [3:0] OpNot   = 4'b1001;
    localparam logic [3:0] OpJmp   = 4'b1100;
    localparam logic [3:0] OpPause = 4'b1101;

    // PCMUX
    localparam logic [1:0] PcmuxBus   = 2'b00;
    localparam logic [1:0] PcmuxAdder = 2'b01;
    localparam logic [1:0] PcmuxPcInc = 2'b10;

    // ADDR2MUX
    localparam logic [1:0] Addr2Sext11 = 2'b00;
    localparam logic [1:0] Addr2Sext9  = 2'b01;
    localparam logic [1:0] Addr2Sext6  = 2'b10;
    localparam logic [1:0] Addr2Zero   = 2'b11;

    // ALUK
    localparam logic [1:0] AlukAdd   = 2'b00;
    localparam logic [1:0] AlukAnd   = 2'b01;
    localparam logic [1:0] AlukNot   = 2'b10;
    localparam logic [1:0] AlukPassA = 2'b11;

endpackage

// File: rtl/lc3_control_unit_mem_wait_timer.sv
// Memory access wait counter: loaded one cycle before a memory state is entered,
// then counts down to zero and holds there.
module mem_wait_timer #(
    parameter int unsigned MEM_WAIT = 3
) (
    input  logic Clk,
    input  logic Reset_ah,
    input  logic start,
    output logic done
);

    localparam logic [3:0] LoadVal = 4'(MEM_WAIT - 1);

    logic [3:0] count_q, count_d;

    // Load on start, otherwise count down and saturate at zero
    always_comb begin
        count_d = count_q;
        if (start) begin
            count_d = LoadVal;
        end else if (count_q != 4'd0) begin
            count_d = count_q - 4'd1;
        end
    end

    // Counter register, cleared asynchronously so a reset mid-access leaves no residue
    always_ff @(posedge Clk or posedge Reset_ah) begin
        if (Reset_ah) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == 4'd0);

endmodule

// File: rtl/lc3_control_unit.sv
// LC-3 instruction sequencer: Moore FSM driving datapath loads, gates, selects
// and the active-low SRAM strobes.
module lc3_control_unit
    import lc3_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 3
) (
    input  logic       Clk,
    input  logic       Reset_ah,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       MIO_EN,
    output logic       Mem_CE,
    output logic       Mem_UB,
    output logic       Mem_LB,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    state_t state_q, state_d;
    logic   wait_start;
    logic   wait_done;

    // States that always lead into a memory state arm the timer
    assign wait_start = (state_q == StFetch1) || (state_q == StLdr1) || (state_q == StStr2);

    mem_wait_timer #(
        .MEM_WAIT (MEM_WAIT)
    ) u_timer (
        .Clk      (Clk),
        .Reset_ah (Reset_ah),
        .start    (wait_start),
        .done     (wait_done)
    );

    // State register
    always_ff @(posedge Clk or posedge Reset_ah) begin
        if (Reset_ah) begin
            state_q <= StHalted;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StHalted:  if (Run) state_d = StFetch1;
            StFetch1:  state_d = StFetch2;
            StFetch2:  if (wait_done) state_d = StFetch3;
            StFetch3:  state_d = StDecode;
            StDecode: begin
                case (Opcode)
                    OpAdd:   state_d = StAdd;
                    OpAnd:   state_d = StAnd;
                    OpNot:   state_d = StNot;
                    OpBr:    state_d = StBr;
                    OpJmp:   state_d = StJmp;
                    OpJsr:   state_d = StJsr1;
                    OpLdr:   state_d = StLdr1;
                    OpStr:   state_d = StStr1;
                    OpPause: state_d = StPause1;
                    default: state_d = StFetch1;
                endcase
            end
            StAdd, StAnd, StNot: state_d = StFetch1;
            StBr:      state_d = BEN ? StBrTaken : StFetch1;
            StBrTaken: state_d = StFetch1;
            StJmp:     state_d = StFetch1;
            StJsr1:    state_d = StJsr2;
            StJsr2:    state_d = StFetch1;
            StLdr1:    state_d = StLdr2;
            StLdr2:    if (wait_done) state_d = StLdr3;
            StLdr3:    state_d = StFetch1;
            StStr1:    state_d = StStr2;
            StStr2:    state_d = StStr3;
            StStr3:    if (wait_done) state_d = StFetch1;
            StPause1:  if (Continue) state_d = StPause2;
            // Wait for release so one press executes exactly one pause
            StPause2:  if (!Continue) state_d = StFetch1;
            default:   state_d = StHalted;
        endcase
    end

    // Moore output decode
    always_comb begin
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = PcmuxBus;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = Addr2Sext11;
        ALUK       = AlukAdd;
        MIO_EN     = 1'b0;
        Mem_CE     = 1'b0;
        Mem_UB     = 1'b0;
        Mem_LB     = 1'b0;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;
        case (state_q)
            StHalted: begin
                Mem_CE = 1'b1;
                Mem_UB = 1'b1;
                Mem_LB = 1'b1;
            end
            StFetch1: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                PCMUX  = PcmuxPcInc;
                LD_PC  = 1'b1;
            end
            StFetch2, StLdr2: begin
                Mem_OE = 1'b0;
                MIO_EN = 1'b1;
                LD_MDR = 1'b1;
            end
            StFetch3: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            StDecode: LD_BEN = 1'b1;
            StAdd, StAnd, StNot: begin
                SR1MUX  = 1'b1;
                SR2MUX  = IR_5;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                ALUK    = (state_q == StAdd) ? AlukAdd :
                          (state_q == StAnd) ? AlukAnd : AlukNot;
            end
            StBrTaken: begin
                ADDR1MUX = 1'b1;
                ADDR2MUX = Addr2Sext9;
                PCMUX    = PcmuxAdder;
                LD_PC    = 1'b1;
            end
            StJmp: begin
                SR1MUX   = 1'b1;
                ADDR2MUX = Addr2Zero;
                PCMUX    = PcmuxAdder;
                LD_PC    = 1'b1;
            end
            StJsr1: begin
                GatePC = 1'b1;
                DRMUX  = 1'b1;
                LD_REG = 1'b1;
            end
            StJsr2: begin
                if (IR_11) begin
                    ADDR1MUX = 1'b1;
                    ADDR2MUX = Addr2Sext11;
                end else begin
                    SR1MUX   = 1'b1;
                    ADDR2MUX = Addr2Zero;
                end
                PCMUX = PcmuxAdder;
                LD_PC = 1'b1;
            end
            StLdr1, StStr1: begin
                SR1MUX     = 1'b1;
                ADDR2MUX   = Addr2Sext6;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
            end
            StLdr3: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            StStr2: begin
                ALUK    = AlukPassA;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
            end
            StStr3:   Mem_WE = 1'b0;
            StPause1: LD_LED = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lc3_control_unit.sv
// Self-checking bench for lc3_control_unit (MEM_WAIT = 3).
module tb_lc3_control_unit;

    typedef enum logic [4:0] {
        PHalted, PFetch1, PFetch2, PFetch3, PDecode, PAdd, PAnd, PNot, PBr, PBrTaken,
        PJmp, PJsr1, PJsr2, PLdr1, PLdr2, PLdr3, PStr1, PStr2, PStr3, PPause1, PPause2
    } phase_e;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic       drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mio_en, ce, ub, lb, oe, we;
    } out_t;

    typedef struct packed {
        logic [3:0]      op;
        logic            ir5, ir11, ben;
        int              n;
        logic [0:5][4:0] seq;
    } vec_t;

    logic Clk = 1'b0, Reset_ah = 1'b1, Run = 1'b0, Continue = 1'b0;
    logic [3:0] Opcode = 4'b0000;
    logic IR_5 = 1'b0, IR_11 = 1'b0, BEN = 1'b0;
    logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN;
    logic Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

    out_t act;
    out_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    vec_t vecs[12];

    lc3_control_unit #(.MEM_WAIT(3)) dut (
        .Clk(Clk), .Reset_ah(Reset_ah), .Run(Run), .Continue(Continue), .Opcode(Opcode),
        .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
        .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .MIO_EN(MIO_EN),
        .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    always #5 Clk = ~Clk;

    assign act = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                  GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
                  ADDR1MUX, ADDR2MUX, ALUK, MIO_EN, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE};

    // Expected outputs for each state, written straight from the state descriptions
    function automatic out_t exp_out(input phase_e p, input logic ir5, input logic ir11);
        out_t o;
        o = '0;
        o.oe = 1'b1;
        o.we = 1'b1;
        case (p)
            PHalted:  begin o.ce = 1; o.ub = 1; o.lb = 1; end
            PFetch1:  begin o.gate_pc = 1; o.ld_mar = 1; o.pcmux = 2'b10; o.ld_pc = 1; end
            PFetch2, PLdr2: begin o.oe = 0; o.mio_en = 1; o.ld_mdr = 1; end
            PFetch3:  begin o.gate_mdr = 1; o.ld_ir = 1; end
            PDecode:  o.ld_ben = 1;
            PAdd, PAnd, PNot: begin
                o.sr1mux = 1; o.sr2mux = ir5; o.gate_alu = 1; o.ld_reg = 1; o.ld_cc = 1;
                o.aluk = (p == PAdd) ? 2'b00 : (p == PAnd) ? 2'b01 : 2'b10;
            end
            PBrTaken: begin o.addr1mux = 1; o.addr2mux = 2'b01; o.pcmux = 2'b01; o.ld_pc = 1; end
            PJmp:     begin o.sr1mux = 1; o.addr2mux = 2'b11; o.pcmux = 2'b01; o.ld_pc = 1; end
            PJsr1:    begin o.gate_pc = 1; o.drmux = 1; o.ld_reg = 1; end
            PJsr2: begin
                if (ir11) begin o.addr1mux = 1; o.addr2mux = 2'b00; end
                else begin o.sr1mux = 1; o.addr2mux = 2'b11; end
                o.pcmux = 2'b01; o.ld_pc = 1;
            end
            PLdr1, PStr1: begin o.sr1mux = 1; o.addr2mux = 2'b10; o.gate_marmux = 1; o.ld_mar = 1; end
            PLdr3:    begin o.gate_mdr = 1; o.ld_reg = 1; o.ld_cc = 1; end
            PStr2:    begin o.aluk = 2'b11; o.gate_alu = 1; o.ld_mdr = 1; end
            PStr3:    o.we = 0;
            PPause1:  o.ld_led = 1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic vec_t mk(input logic [3:0] op, input logic ir5, input logic ir11,
                                input logic ben, input int n, input phase_e p0, input phase_e p1,
                                input phase_e p2, input phase_e p3, input phase_e p4,
                                input phase_e p5);
        vec_t v;
        v.op = op; v.ir5 = ir5; v.ir11 = ir11; v.ben = ben; v.n = n;
        v.seq = {p0, p1, p2, p3, p4, p5};
        return v;
    endfunction

    task automatic check(input string nm);
        out_t e;
        e = exp_q.pop_front();
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL %s: outputs got %h want %h", nm, act, e);
        end
        total++;
        if (!act.oe && !act.we) begin
            bad++;
            $display("FAIL %s_oe_we: got OE=%b WE=%b want not both low", nm, act.oe, act.we);
        end
    endtask

    // Push the expectation, advance one clock, compare away from the edge
    task automatic step(input phase_e p, input string nm);
        exp_q.push_back(exp_out(p, IR_5, IR_11));
        @(posedge Clk);
        #1;
        check(nm);
    endtask

    // From a sampled FETCH1, walk through the read wait, FETCH3 and DECODE
    task automatic run_fetch(input string nm);
        for (int k = 0; k < 3; k++) step(PFetch2, {nm, "_fetch2"});
        step(PFetch3, {nm, "_fetch3"});
        step(PDecode, {nm, "_decode"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(4'b0001, 1, 0, 0, 2, PAdd, PFetch1, PFetch1, PFetch1, PFetch1, PFetch1);
        vecs[1]  = mk(4'b0001, 0, 0, 0, 2, PAdd, PFetch1, PFetch1, PFetch1, PFetch1, PFetch1);
        vecs[2]  = mk(4'b0101, 0, 0, 0, 2, PAnd, PFetch1, PFetch1, PFetch1, PFetch1, PFetch1);
        vecs[3]  = mk(4'b1001, 1, 0, 0, 2, PNot, PFetch1, PFetch1, PFetch1, PFetch1, PFetch1);
        vecs[4]  = mk(4'b0000, 0, 0, 1, 3, PBr, PBrTaken, PFetch1, PFetch1, PFetch1, PFetch1);
        vecs[5]  = mk(4'b0000, 0, 0, 0, 2, PBr, PFetch1, PFetch1, PFetch1, PFetch1, PFetch1);
        vecs[6]  = mk(4'b1100, 0, 0, 0, 2, PJmp, PFetch1, PFetch1, PFetch1, PFetch1, PFetch1);
        vecs[7]  = mk(4'b0100, 0, 1, 0, 3, PJsr1, PJsr2, PFetch1, PFetch1, PFetch1, PFetch1);
        vecs[8]  = mk(4'b0100, 0, 0, 0, 3, PJsr1, PJsr2, PFetch1, PFetch1, PFetch1, PFetch1);
        vecs[9]  = mk(4'b0110, 0, 0, 0, 6, PLdr1, PLdr2, PLdr2, PLdr2, PLdr3, PFetch1);
        vecs[10] = mk(4'b0111, 0, 0, 0, 6, PStr1, PStr2, PStr3, PStr3, PStr3, PFetch1);
        vecs[11] = mk(4'b0010, 0, 0, 0, 1, PFetch1, PFetch1, PFetch1, PFetch1, PFetch1, PFetch1);

        // Reset state
        @(posedge Clk);
        #1;
        exp_q.push_back(exp_out(PHalted, 0, 0));
        check("reset");
        Reset_ah = 1'b0;
        step(PHalted, "halted_idle");
        step(PHalted, "halted_idle");
        Run = 1'b1;
        step(PFetch1, "run_start");
        Run = 1'b0;  // dropping Run after leaving HALTED must not matter

        for (int i = 0; i < 12; i++) begin
            Opcode = vecs[i].op;
            IR_5   = vecs[i].ir5;
            IR_11  = vecs[i].ir11;
            BEN    = vecs[i].ben;
            run_fetch($sformatf("vec%0d", i));
            for (int k = 0; k < vecs[i].n; k++)
                step(phase_e'(vecs[i].seq[k]), $sformatf("vec%0d_s%0d", i, k));
        end

        // PAUSE: hold Continue low, then a 5-cycle press gives one return to FETCH1
        Opcode = 4'b1101;
        IR_5 = 1'b0;
        IR_11 = 1'b0;
        BEN = 1'b0;
        run_fetch("pause");
        step(PPause1, "pause1_enter");
        for (int k = 0; k < 10; k++) step(PPause1, "pause1_hold");
        Continue = 1'b1;
        for (int k = 0; k < 5; k++) step(PPause2, "pause2_press");
        Continue = 1'b0;
        Opcode = 4'b0010;
        step(PFetch1, "pause_release");
        run_fetch("after_pause");
        step(PFetch1, "after_pause_nop");

        // Async reset during the second LDR2 cycle
        Opcode = 4'b0110;
        run_fetch("ldr_rst");
        step(PLdr1, "ldr_rst_ldr1");
        step(PLdr2, "ldr_rst_ldr2a");
        step(PLdr2, "ldr_rst_ldr2b");
        #1;
        Reset_ah = 1'b1;
        exp_q.push_back(exp_out(PHalted, 0, 0));
        #1;
        check("async_reset");
        step(PHalted, "reset_held");
        Reset_ah = 1'b0;
        for (int k = 0; k < 3; k++) step(PHalted, "no_fetch_without_run");
        Run = 1'b1;
        step(PFetch1, "rerun");
        Run = 1'b0;
        run_fetch("ldr_after");
        step(PLdr1, "ldr_after_ldr1");
        for (int k = 0; k < 3; k++) step(PLdr2, "ldr_after_ldr2");
        step(PLdr3, "ldr_after_ldr3");
        step(PFetch1, "ldr_after_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lc3_control_unit.md
Name: lc3_control_unit

Overview:
Instruction-sequencing FSM that drives the LC-3 datapath. It is the upstream control stage for every datapath load enable, bus gate, mux select and ALU function, and for the SRAM strobes. It consumes the opcode, IR bits and BEN fed back from the datapath. Memory accesses last a programmable number of wait cycles.

Parameters:
MEM_WAIT, 3, cycles the read/write strobe is held per memory access (legal 1..15)

Ports:
Clk  in  1  system clock, rising edge
Reset_ah  in  1  asynchronous active-high reset
Run  in  1  start execution from HALTED (level)
Continue  in  1  resume from PAUSE (level)
Opcode  in  4  IR[15:12]
IR_5  in  1  IR[5], immediate select for ADD/AND
IR_11  in  1  IR[11], JSR vs JSRR
BEN  in  1  registered branch enable from datapath
LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register load enables
GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers, at most one high per cycle
PCMUX  out  2  00 BUS, 01 adder, 10 PC+1
DRMUX  out  1  0 IR[11:9], 1 R7
SR1MUX  out  1  0 IR[11:9], 1 IR[8:6]
SR2MUX  out  1  0 SR2 register, 1 SEXT(imm5)
ADDR1MUX  out  1  0 SR1, 1 PC
ADDR2MUX  out  2  00 SEXT11, 01 SEXT9, 10 SEXT6, 11 zero
ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASS A
MIO_EN  out  1  1 = MDR loads from memory, 0 = from bus
Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  SRAM strobes, active low

Behaviour:
- Outputs are Moore-decoded from state only. Default in every state: all loads/gates 0, all selects 0, Mem_CE/UB/LB 0 except in HALTED (1), Mem_OE/WE 1.
- Reset_ah is asynchronous. It forces HALTED and clears the wait counter at once, including mid-access. Outputs take HALTED values in the same cycle reset is asserted.
- HALTED: Mem_* all 1. Goes to FETCH1 when Run=1.
- FETCH1: GatePC, LD_MAR, PCMUX=10, LD_PC.
- FETCH2: Mem_OE=0, MIO_EN=1, LD_MDR=1 on every cycle. Stays for exactly MEM_WAIT cycles, then goes to FETCH3.
- FETCH3: GateMDR, LD_IR.
- DECODE: LD_BEN. Branch on Opcode:
  - 0001 → ADD; 0101 → AND; 1001 → NOT; 0000 → BR; 1100 → JMP; 0100 → JSR1.
  - 0110 → LDR1; 0111 → STR1; 1101 → PAUSE1.
  - Any other opcode → FETCH1 (treated as NOP).
- ADD/AND/NOT: SR1MUX=1, SR2MUX=IR_5, ALUK 00/01/10, GateALU, LD_REG, LD_CC. Then FETCH1.
- BR: if BEN → BR_TAKEN, else → FETCH1. BEN is sampled in BR, one cycle after the LD_BEN load.
- BR_TAKEN: ADDR1MUX=1, ADDR2MUX=01, PCMUX=01, LD_PC. Then FETCH1.
- JMP: SR1MUX=1, ADDR1MUX=0, ADDR2MUX=11, PCMUX=01, LD_PC. Then FETCH1.
- JSR1: GatePC, DRMUX=1, LD_REG (R7←PC). Then JSR2.
- JSR2: if IR_11, ADDR1MUX=1, ADDR2MUX=00; else SR1MUX=1, ADDR1MUX=0, ADDR2MUX=11. PCMUX=01, LD_PC. Then FETCH1.
- LDR1: SR1MUX=1, ADDR1MUX=0, ADDR2MUX=10, GateMARMUX, LD_MAR.
- LDR2: read, identical to FETCH2 for MEM_WAIT cycles.
- LDR3: GateMDR, LD_REG, LD_CC. Then FETCH1.
- STR1: same as LDR1.
- STR2: SR1MUX=0, ALUK=11, GateALU, MIO_EN=0, LD_MDR.
- STR3: Mem_WE=0 for exactly MEM_WAIT cycles, with Mem_OE=1 throughout. Then FETCH1.
- PAUSE1: LD_LED. Stays while Continue=0; → PAUSE2 when Continue=1.
- PAUSE2: stays while Continue=1; → FETCH1 on release, so one press executes one pause.
- Wait counter: 4-bit, loads MEM_WAIT-1 on entry to a memory state and decrements each cycle. The state exits when the counter is 0. It never wraps.
- Run deasserted after leaving HALTED has no effect; only reset returns to HALTED.

Decomposition:
- Package lc3_ctrl_pkg holds:
  - the state enum;
  - opcode constants;
  - the PCMUX/ADDR2MUX/ALUK encodings listed above.
- Sub-module mem_wait_timer holds the wait counter. Ports: Clk, Reset_ah, start, done.

Test Plan:
- Reset, then Run=1 → FETCH1 on the next edge. Mem_OE low for exactly 3 cycles; LD_IR high one cycle later.
- Opcode 0001, IR_5=1 → ADD state: GateALU=1, SR2MUX=1, LD_REG=1, LD_CC=1 for one cycle, then FETCH1.
- Opcode 0000, BEN=1 → BR_TAKEN with PCMUX=01, ADDR2MUX=01. With BEN=0 → FETCH1 directly, LD_PC never asserted.
- Opcode 0111 → Mem_WE low for exactly MEM_WAIT cycles. Mem_OE=1 throughout; no cycle has both Mem_OE and Mem_WE low.
- Opcode 1101 with Continue held 0 for 10 cycles → stays in PAUSE1, LD_LED=1. Continue pulse of 5 cycles → exactly one return to FETCH1, after release.
- Reset_ah asserted during the 2nd cycle of LDR2 → outputs take HALTED values immediately (Mem_OE=1, Mem_CE=1). After release, no fetch occurs until Run=1.
